uart_frame_decoder: RTL and testbench

Parametrised UART command-frame decoder for the digital clock. Consumes the byte stream from the UART receiver and hunts for a header byte. It buffers a fixed-length payload plus an 8-bit checksum, then validates every field range. Only on a fully valid frame does it commit mode, adjust and alarm settings to the clock core; bad or truncated frames leave all outputs untouched and raise an error pulse.

---
 rtl/uart_frame_decoder.sv | 182 ++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// UART command-frame decoder: hunts for HEADER, buffers payload + checksum, validates
// every field and commits all clock settings atomically, or pulses frame_err.
module uart_frame_decoder #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         N_ALARM     = 3,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [2:0]           mode,
  output logic [1:0]           adjust_mode,
  output logic [1:0]           adjust_way,
  output logic [5:0]           adjust_hour,
  output logic [5:0]           adjust_minute,
  output logic [5:0]           adjust_second,
  output logic [6*N_ALARM-1:0] alarm_hour,
  output logic [6*N_ALARM-1:0] alarm_minute,
  output logic [6*N_ALARM-1:0] alarm_second,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int P     = 6 + 3 * N_ALARM;
  localparam int IDX_W = $clog2(P);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CSUM, S_CHECK} state_t;

  state_t           state, state_nx;
  logic [7:0]       shadow [P];
  logic [IDX_W-1:0] idx;
  logic [7:0]       sum_acc;
  logic [7:0]       csum_rx;
  logic [CNT_W-1:0] idle_cnt;
  logic             check_phase;
  logic             csum_bad_q;
  logic             range_bad_q;
  logic             range_bad;
  logic             timeout;
  logic             commit;
  logic             reject;
  logic [1:0]       reject_code;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (rx_valid && rx_data == HEADER) state_nx = S_PAYLOAD;
      S_PAYLOAD: begin
        if (rx_valid) begin
          if (idx == IDX_LAST) state_nx = S_CSUM;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      S_CSUM: begin
        if (rx_valid)     state_nx = S_CHECK;
        else if (timeout) state_nx = S_IDLE;
      end
      S_CHECK:   if (check_phase) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // CHECK spans two cycles: phase 0 registers the compare results, phase 1 commits or rejects.
  always_comb begin
    busy        = (state != S_IDLE);
    timeout     = (state == S_PAYLOAD || state == S_CSUM) && !rx_valid && (idle_cnt == CNT_LAST);
    commit      = (state == S_CHECK) && check_phase && !csum_bad_q && !range_bad_q;
    reject      = ((state == S_CHECK) && check_phase && (csum_bad_q || range_bad_q)) || timeout;
    reject_code = timeout ? 2'd3 : (csum_bad_q ? 2'd1 : 2'd2);
  end

  // Range rules look at the whole byte so stray upper bits are rejected, not truncated.
  always_comb begin
    range_bad = (shadow[0] > 8'd7)  || (shadow[1] > 8'd3)  || (shadow[2] > 8'd2) ||
                (shadow[3] > 8'd23) || (shadow[4] > 8'd59) || (shadow[5] > 8'd59);
    for (int k = 0; k < N_ALARM; k++) begin
      if (shadow[6+3*k] > 8'd23 || shadow[7+3*k] > 8'd59 || shadow[8+3*k] > 8'd59)
        range_bad = 1'b1;
    end
  end

  // NOTE: the shadow buffer is reset explicitly, so it must stay in flops rather than RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P; i++) shadow[i] <= '0;
      idx         <= '0;
      sum_acc     <= '0;
      csum_rx     <= '0;
      idle_cnt    <= '0;
      check_phase <= 1'b0;
      csum_bad_q  <= 1'b0;
      range_bad_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          idx         <= '0;
          sum_acc     <= '0;
          idle_cnt    <= '0;
          check_phase <= 1'b0;
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            shadow[idx] <= rx_data;
            sum_acc     <= sum_acc + rx_data;
            idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            idle_cnt    <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            csum_rx  <= rx_data;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          check_phase <= ~check_phase;
          if (!check_phase) begin
            csum_bad_q  <= (csum_rx != sum_acc);
            range_bad_q <= range_bad;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  // Every setting loads from the shadow buffer on the same edge, so a frame lands atomically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode          <= '0;
      adjust_mode   <= '0;
      adjust_way    <= '0;
      adjust_hour   <= '0;
      adjust_minute <= '0;
      adjust_second <= '0;
      alarm_hour    <= '0;
      alarm_minute  <= '0;
      alarm_second  <= '0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
    end else begin
      frame_ok  <= commit;
      frame_err <= reject;
      if (commit) begin
        mode          <= shadow[0][2:0];
        adjust_mode   <= shadow[1][1:0];
        adjust_way    <= shadow[2][1:0];
        adjust_hour   <= shadow[3][5:0];
        adjust_minute <= shadow[4][5:0];
        adjust_second <= shadow[5][5:0];
        for (int k = 0; k < N_ALARM; k++) begin
          alarm_hour[6*k +: 6]   <= shadow[6+3*k][5:0];
          alarm_minute[6*k +: 6] <= shadow[7+3*k][5:0];
          alarm_second[6*k +: 6] <= shadow[8+3*k][5:0];
        end
        err_code <= '0;
      end else if (reject) begin
        err_code <= reject_code;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: table of whole frames with expected settings,
// plus hand sequences for timeout, back-to-back frames and mid-frame reset.
module tb_uart_frame_decoder;

  localparam int N_ALARM     = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int FLEN        = 17;
  localparam int NVEC        = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [2:0]  mode;
  logic [1:0]  adjust_mode, adjust_way, err_code;
  logic [5:0]  adjust_hour, adjust_minute, adjust_second;
  logic [17:0] alarm_hour, alarm_minute, alarm_second;
  logic        frame_ok, frame_err, busy;

  uart_frame_decoder #(.HEADER(8'hA5), .N_ALARM(N_ALARM), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mode(mode), .adjust_mode(adjust_mode), .adjust_way(adjust_way),
    .adjust_hour(adjust_hour), .adjust_minute(adjust_minute), .adjust_second(adjust_second),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_second(alarm_second),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          npre;
    logic [7:0]  pre [3];
    logic [7:0]  b [FLEN];
    logic        exp_ok;
    logic [1:0]  exp_code;
    logic [2:0]  exp_mode;
    logic [1:0]  exp_adjm, exp_adjw;
    logic [5:0]  exp_ah, exp_am, exp_as;
    logic [17:0] exp_alh, exp_alm, exp_als;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk_vec(input string name, input logic ok, input logic [1:0] code,
                                  input logic [2:0] m, input logic [1:0] adjm, input logic [1:0] adjw,
                                  input logic [5:0] ah, input logic [5:0] am, input logic [5:0] as_,
                                  input logic [17:0] alh, input logic [17:0] alm, input logic [17:0] als);
    vec_t v;
    v.name = name;  v.npre = 0;  v.pre = '{8'h00, 8'h00, 8'h00};
    for (int i = 0; i < FLEN; i++) v.b[i] = 8'h00;
    v.exp_ok = ok;  v.exp_code = code;  v.exp_mode = m;
    v.exp_adjm = adjm;  v.exp_adjw = adjw;
    v.exp_ah = ah;  v.exp_am = am;  v.exp_as = as_;
    v.exp_alh = alh;  v.exp_alm = alm;  v.exp_als = als;
    return v;
  endfunction

  // Driven on a falling edge; the DUT samples it on the following rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ":mode"},    32'(mode),          32'(v.exp_mode));
    check({tag, ":adj_m"},   32'(adjust_mode),   32'(v.exp_adjm));
    check({tag, ":adj_w"},   32'(adjust_way),    32'(v.exp_adjw));
    check({tag, ":adj_hms"}, 32'({adjust_hour, adjust_minute, adjust_second}),
                             32'({v.exp_ah, v.exp_am, v.exp_as}));
    check({tag, ":al_h"},    32'(alarm_hour),    32'(v.exp_alh));
    check({tag, ":al_m"},    32'(alarm_minute),  32'(v.exp_alm));
    check({tag, ":al_s"},    32'(alarm_second),  32'(v.exp_als));
  endtask

  // Last byte sampled at edge T: still busy after T+1, result pulse after T+2, gone after T+3.
  task automatic apply_vec(input vec_t v, input bit chk_tail);
    for (int i = 0; i < v.npre; i++) send_byte(v.pre[i]);
    for (int i = 0; i < FLEN; i++) send_byte(v.b[i]);
    @(negedge clk);
    check({v.name, ":t1"}, 32'({frame_ok, frame_err, busy}), 32'(3'b001));
    @(negedge clk);
    check({v.name, ":t2_pulse"}, 32'({frame_ok, frame_err, busy}), 32'({v.exp_ok, ~v.exp_ok, 1'b0}));
    check({v.name, ":err_code"}, 32'(err_code), 32'(v.exp_code));
    check_outputs(v.name, v);
    if (chk_tail) begin
      @(negedge clk);
      check({v.name, ":t3_single"}, 32'({frame_ok, frame_err}), 32'(2'b00));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame 1 from the reference stimulus; alarms (7,30,0) (8,0,0) (23,59,59).
    vecs[0] = mk_vec("valid1", 1'b1, 2'd0, 3'd1, 2'd0, 2'd0, 6'd12, 6'd34, 6'd56,
                     18'h17207, 18'h3B01E, 18'h3B000);
    vecs[0].b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h0C, 8'h22, 8'h38, 8'h07, 8'h1E,
                  8'h00, 8'h08, 8'h00, 8'h00, 8'h17, 8'h3B, 8'h3B, 8'h21};
    vecs[1] = vecs[0];  vecs[1].name = "bad_csum";
    vecs[1].exp_ok = 1'b0;  vecs[1].exp_code = 2'd1;  vecs[1].b[16] = 8'h22;
    vecs[2] = vecs[1];  vecs[2].name = "range_adj_h";
    vecs[2].exp_code = 2'd2;  vecs[2].b[4] = 8'h18;  vecs[2].b[16] = 8'h2D;
    // Frame 2 sums to 0xA5, so the checksum byte equals HEADER; preceded by noise.
    vecs[3] = mk_vec("noise_a5csum", 1'b1, 2'd0, 3'd1, 2'd0, 2'd0, 6'd12, 6'd34, 6'd56,
                     18'h175C7, 18'h3B77B, 18'h3B03B);
    vecs[3].b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h0C, 8'h22, 8'h38, 8'h07, 8'h3B,
                  8'h3B, 8'h17, 8'h1D, 8'h00, 8'h17, 8'h3B, 8'h3B, 8'hA5};
    vecs[3].npre = 3;  vecs[3].pre = '{8'h00, 8'hFF, 8'h3C};
    // Every field at its upper limit, alarms zero; sum 0x99.
    vecs[4] = mk_vec("max_fields", 1'b1, 2'd0, 3'd7, 2'd3, 2'd2, 6'd23, 6'd59, 6'd59,
                     18'h0, 18'h0, 18'h0);
    vecs[4].b = '{8'hA5, 8'h07, 8'h03, 8'h02, 8'h17, 8'h3B, 8'h3B, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99};
    vecs[5] = vecs[4];  vecs[5].name = "range_mode";
    vecs[5].exp_ok = 1'b0;  vecs[5].exp_code = 2'd2;  vecs[5].b[1] = 8'h08;  vecs[5].b[16] = 8'h9A;
    vecs[6] = vecs[5];  vecs[6].name = "range_way";
    vecs[6].b[1] = 8'h07;  vecs[6].b[3] = 8'h03;
    vecs[7] = vecs[5];  vecs[7].name = "csum_over_range";
    vecs[7].exp_code = 2'd1;  vecs[7].b[16] = 8'h99;
    vecs[8] = vecs[5];  vecs[8].name = "range_alarm_h";
    vecs[8].b[1] = 8'h07;  vecs[8].b[7] = 8'h18;  vecs[8].b[16] = 8'hB1;
    vecs[9] = vecs[3];  vecs[9].name = "b2b_first";  vecs[9].npre = 0;

    repeat (2) @(negedge clk);
    check("reset:pulses", 32'({frame_ok, frame_err, busy, err_code}), 32'd0);
    check_outputs("reset", mk_vec("reset", 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0,
                                  18'h0, 18'h0, 18'h0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) apply_vec(vecs[v], 1'b1);

    // Truncated frame: header plus five payload bytes, then silence.
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h22);
    for (int k = 1; k < TIMEOUT_CYC; k++) begin
      @(negedge clk);
      check("timeout:early", 32'({frame_err, busy}), 32'(2'b01));
    end
    @(negedge clk);
    check("timeout:fire", 32'({frame_ok, frame_err, busy}), 32'(3'b010));
    check("timeout:code", 32'(err_code), 32'd3);
    check_outputs("timeout_held", vecs[4]);
    @(negedge clk);
    check("timeout:single", 32'(frame_err), 32'd0);
    apply_vec(vecs[0], 1'b1);

    // Back-to-back: the second header lands on the edge right after the commit edge.
    apply_vec(vecs[9], 1'b0);
    apply_vec(vecs[0], 1'b1);

    // Reset in the middle of a payload discards it and clears every output.
    send_byte(8'hA5);
    send_byte(8'h07); send_byte(8'h03); send_byte(8'h02); send_byte(8'h17);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset:pulses", 32'({frame_ok, frame_err, busy, err_code}), 32'd0);
    check_outputs("midreset", mk_vec("midreset", 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0,
                                     18'h0, 18'h0, 18'h0));
    rst_n = 1'b1;
    @(negedge clk);
    apply_vec(vecs[4], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
